// File: rtl/mac_stream_pkg.sv
// Shared definitions for the MAC operand streamer.
//   state_t        - streamer FSM states (idle, issuing reads, draining FIFO)
//   TDATA_LANES    - number of operand lanes packed into TDATA {weight, activation}
//   TID_W          - width of the vector index carried on TID
//   VEC_LEN_W      - width of the per-vector pair count input
//   NUM_VECS_W     - width of the per-job vector count input
//   is_empty_job() - true when a job has nothing to stream
package mac_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int TDATA_LANES = 2;
    localparam int TID_W       = 8;
    localparam int VEC_LEN_W   = 16;
    localparam int NUM_VECS_W  = 8;

    function automatic logic is_empty_job(input logic [VEC_LEN_W-1:0]  vec_len,
                                          input logic [NUM_VECS_W-1:0] num_vecs);
        return (vec_len == '0) || (num_vecs == '0);
    endfunction

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry output FIFO holding complete AXI-Stream beats.
//   clk, rst   - clock and synchronous active-high reset (control only)
//   push       - write push_data this cycle (caller guarantees space)
//   push_data  - beat payload to store
//   ready      - downstream TREADY; a pop happens when valid && ready
//   valid      - FIFO non-empty (drives TVALID)
//   data       - head payload, forced to zero while empty
//   count      - current occupancy, 0..2
module axis_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;

    assign valid = (count != 2'd0);
    assign pop   = valid && ready;
    // The head slot is never the write target while occupied, so the
    // presented payload stays stable across stalls.
    assign data  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mac_operand_streamer.sv
// Streams (weight, activation) operand pairs from two BRAM read ports into
// an AXI-Stream master feeding a MAC.
//   ACLK, ARESET          - clock, synchronous active-high reset
//   START                 - job request, honoured only in idle
//   VEC_LEN, NUM_VECS     - pairs per vector, vectors per job
//   BUSY, DONE            - job in progress, one-cycle completion pulse
//   W_EN/W_ADDR/W_DOUT    - weight BRAM read port (1-cycle latency)
//   A_EN/A_ADDR/A_DOUT    - activation BRAM read port (1-cycle latency)
//   MD_AXIS_*             - output stream; TDATA = {weight, activation},
//                           TUSER = first pair, TLAST = last pair, TID = vector
module mac_operand_streamer
    import mac_stream_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_ADDR_WIDTH = 10
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic                                START,
    input  logic [VEC_LEN_W-1:0]                VEC_LEN,
    input  logic [NUM_VECS_W-1:0]               NUM_VECS,
    output logic                                BUSY,
    output logic                                DONE,
    output logic                                W_EN,
    output logic [C_ADDR_WIDTH-1:0]             W_ADDR,
    input  logic [C_DATA_WIDTH-1:0]             W_DOUT,
    output logic                                A_EN,
    output logic [C_ADDR_WIDTH-1:0]             A_ADDR,
    input  logic [C_DATA_WIDTH-1:0]             A_DOUT,
    output logic                                MD_AXIS_TVALID,
    input  logic                                MD_AXIS_TREADY,
    output logic [TDATA_LANES*C_DATA_WIDTH-1:0] MD_AXIS_TDATA,
    output logic                                MD_AXIS_TLAST,
    output logic                                MD_AXIS_TUSER,
    output logic [TID_W-1:0]                    MD_AXIS_TID
);

    localparam int TDATA_W = TDATA_LANES * C_DATA_WIDTH;
    localparam int PAY_W   = TDATA_W + 2 + TID_W;

    state_t                  state;
    logic                    run_first;
    logic [VEC_LEN_W-1:0]    vec_len_q;
    logic [NUM_VECS_W-1:0]   num_vecs_q;
    logic [VEC_LEN_W-1:0]    pair_cnt;
    logic [NUM_VECS_W-1:0]   vec_cnt;
    logic [C_ADDR_WIDTH-1:0] w_addr_q;
    logic [C_ADDR_WIDTH-1:0] a_addr_q;

    logic                    vld_p1;
    logic                    user_p1;
    logic                    last_p1;
    logic [TID_W-1:0]        tid_p1;

    logic                    fifo_vld;
    logic [PAY_W-1:0]        fifo_data;
    logic [1:0]              fifo_cnt;
    logic                    pop;
    logic [2:0]              slots_used;
    logic                    rd_issue;
    logic                    pair_last;
    logic                    vec_last;

    assign pop       = fifo_vld && MD_AXIS_TREADY;
    // Occupancy after this cycle's pop plus the read whose data lands next
    // edge; a new read is only issued if it is guaranteed a FIFO slot.
    assign slots_used = 3'(fifo_cnt) - 3'(pop) + 3'(vld_p1);
    assign rd_issue  = !ARESET && (state == ST_RUN) && !run_first && (slots_used < 3'd2);
    assign pair_last = (pair_cnt == vec_len_q - VEC_LEN_W'(1));
    assign vec_last  = (vec_cnt == num_vecs_q - NUM_VECS_W'(1));

    assign W_EN   = rd_issue;
    assign A_EN   = rd_issue;
    assign W_ADDR = w_addr_q;
    assign A_ADDR = a_addr_q;

    // ---- stage p0: job control and read issue ----
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            run_first  <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            vld_p1     <= 1'b0;
            vec_len_q  <= '0;
            num_vecs_q <= '0;
            pair_cnt   <= '0;
            vec_cnt    <= '0;
            w_addr_q   <= '0;
            a_addr_q   <= '0;
        end else begin
            DONE   <= 1'b0;
            vld_p1 <= rd_issue;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        vec_len_q  <= VEC_LEN;
                        num_vecs_q <= NUM_VECS;
                        pair_cnt   <= '0;
                        vec_cnt    <= '0;
                        w_addr_q   <= '0;
                        a_addr_q   <= '0;
                        run_first  <= 1'b1;
                        BUSY       <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The first RUN cycle only screens out empty jobs; it
                    // also aligns the first beat to three edges after START.
                    if (run_first) begin
                        run_first <= 1'b0;
                        if (is_empty_job(vec_len_q, num_vecs_q)) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else if (rd_issue) begin
                        w_addr_q <= w_addr_q + C_ADDR_WIDTH'(1);
                        if (pair_last) begin
                            pair_cnt <= '0;
                            a_addr_q <= '0;
                            vec_cnt  <= vec_cnt + NUM_VECS_W'(1);
                            if (vec_last) state <= ST_DRAIN;
                        end else begin
                            pair_cnt <= pair_cnt + VEC_LEN_W'(1);
                            a_addr_q <= a_addr_q + C_ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!vld_p1 && (fifo_cnt == 2'd1) && pop) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- stage p1: beat sideband travels with the BRAM read ----
    always_ff @(posedge ACLK) begin
        if (rd_issue) begin
            user_p1 <= (pair_cnt == '0);
            last_p1 <= pair_last;
            tid_p1  <= TID_W'(vec_cnt);
        end
    end

    // ---- stage p2: BRAM data plus sideband enter the output FIFO ----
    axis_skid_fifo #(
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (vld_p1),
        .push_data ({W_DOUT, A_DOUT, user_p1, last_p1, tid_p1}),
        .ready     (MD_AXIS_TREADY),
        .valid     (fifo_vld),
        .data      (fifo_data),
        .count     (fifo_cnt)
    );

    assign MD_AXIS_TVALID = fifo_vld;
    assign MD_AXIS_TDATA  = fifo_data[PAY_W-1 -: TDATA_W];
    assign MD_AXIS_TUSER  = fifo_data[TID_W+1];
    assign MD_AXIS_TLAST  = fifo_data[TID_W];
    assign MD_AXIS_TID    = fifo_data[TID_W-1:0];

endmodule
